// File: rtl/button_debouncer_pkg.sv
// Shared timing defaults and counter-width helpers for the button debouncer bank.
// Build option: BUTTON_DEBOUNCER_REPEAT_EN enables auto-repeat press pulses.
package button_debouncer_pkg;

    localparam int DEB_STABLE_5MS_100MHZ = 500000;
    localparam int DEB_REPEAT_DELAY_0S5  = 50000000;
    localparam int DEB_REPEAT_PERIOD_0S1 = 10000000;

    // Bits needed to hold values 0..max_count, never less than one bit.
    function automatic int deb_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int deb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: two-flop synchroniser, stable-count filter, registered pulses.
// Build option: BUTTON_DEBOUNCER_REPEAT_EN adds auto-repeat of the press pulse.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_5MS_100MHZ,
    parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY_0S5,
    parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_0S1
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic button_level,
    output logic button_press,
    output logic button_release
);

    localparam int            CW       = deb_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          rpt_hit;

    // The level flips on the cycle the filter count completes.
    always_comb begin
        flip = (sync2 != button_level) && (cnt == CNT_LAST);
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int            RW         = deb_cnt_width(deb_max(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;

    // A flip cycle (press or release) always wins over a repeat.
    always_comb begin
        rpt_hit = button_level && !flip &&
                  (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (flip) begin
            rpt_cnt   <= '0;
            rpt_first <= sync2;
        end else if (!button_level) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    always_comb begin
        rpt_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            cnt            <= '0;
            button_level   <= 1'b0;
            button_press   <= 1'b0;
            button_release <= 1'b0;
        end else begin
            sync1          <= button;
            sync2          <= sync1;
            button_press   <= (flip && sync2) || rpt_hit;
            button_release <= flip && !sync2;
            if (sync2 == button_level) begin
                cnt <= '0;
            end else if (flip) begin
                button_level <= sync2;
                cnt          <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_debouncer_bank.sv
// Bank of independent debounced button channels with press/release pulses.
// Build option: BUTTON_DEBOUNCER_REPEAT_EN enables auto-repeat while held.
module button_debouncer_bank
    import button_debouncer_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DEB_STABLE_5MS_100MHZ,
    parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY_0S5,
    parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_0S1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_level,
    output logic [CHANNELS-1:0] button_press,
    output logic [CHANNELS-1:0] button_release
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_debouncer_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .button         (button[i]),
            .button_level   (button_level[i]),
            .button_press   (button_press[i]),
            .button_release (button_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Self-checking bench for button_debouncer_bank (4 channels, 4-cycle filter).
// Build option: BUTTON_DEBOUNCER_REPEAT_EN adds expected auto-repeat pulses.
module tb_button_debouncer_bank;

    localparam int W = 28;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button = 4'hF;
    logic [3:0] button_level;
    logic [3:0] button_press;
    logic [3:0] button_release;

    int unsigned cyc = 0;
    logic [W-1:0] ev_q[$];
    logic [W-1:0] chk_q[$];
    bit done = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    button_debouncer_bank #(
        .CHANNELS      (4),
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .button         (button),
        .button_level   (button_level),
        .button_press   (button_press),
        .button_release (button_release)
    );

    // Clock and cycle counter: cyc equals the number of rising edges so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record layout: {cycle[15:0], press, release, level}.
    function automatic logic [W-1:0] pack(input int unsigned c, input logic [3:0] p,
                                          input logic [3:0] r, input logic [3:0] l);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, p, r, l};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int dt, input logic [3:0] p, input logic [3:0] r,
                                input logic [3:0] l);
        ev_q.push_back(pack(cyc + dt, p, r, l));
    endtask

    task automatic expect_now(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        chk_q.push_back(pack(cyc, p, r, l));
    endtask

    // Monitor / scoreboard: pops an expected event whenever any pulse appears.
    always @(negedge clk) begin : monitor
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        logic [15:0]  c16;
        c16 = cyc[15:0];
        act = pack(cyc, button_press, button_release, button_level);
        if ((button_press | button_release) != 4'h0) begin
            vectors++;
            if (ev_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: actual {cyc,press,release,level}=%h required=none", act);
            end else begin
                exp_v = ev_q.pop_front();
                if (act !== exp_v) begin
                    miscompares++;
                    $display("FAIL pulse_event: actual {cyc,press,release,level}=%h required=%h", act, exp_v);
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0][W-1:12] == c16) begin
            exp_v = chk_q.pop_front();
            vectors++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL output_state: actual {cyc,press,release,level}=%h required=%h", act, exp_v);
            end
        end
        if (done) begin
            while (ev_q.size() > 0) begin
                exp_v = ev_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_pulse: actual=none required {cyc,press,release,level}=%h", exp_v);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin : stimulus
        logic [4:0] pat;
        // Reset held with all buttons pressed: outputs stay 0.
        rst    = 1'b1;
        button = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_now(4'h0, 4'h0, 4'h0);
        end
        rst = 1'b0;
        expect_pulse(6, 4'hF, 4'h0, 4'hF);
        tick(6);
        button = 4'h0;
        expect_pulse(6, 4'h0, 4'hF, 4'h0);
        tick(8);
        expect_now(4'h0, 4'h0, 4'h0);

        // Clean press and release on ch0.
        button = 4'h1;
        expect_pulse(6, 4'h1, 4'h0, 4'h1);
        tick(3);
        expect_now(4'h0, 4'h0, 4'h0);
        tick(3);
        button = 4'h0;
        expect_pulse(6, 4'h0, 4'h1, 4'h0);
        tick(8);

        // 3-cycle glitch on ch1 is filtered out.
        button = 4'h2;
        tick(3);
        button = 4'h0;
        tick(10);
        expect_now(4'h0, 4'h0, 4'h0);

        // 4-cycle glitch on ch1 just passes: press, then release.
        button = 4'h2;
        expect_pulse(6, 4'h2, 4'h0, 4'h2);
        tick(4);
        button = 4'h0;
        expect_pulse(6, 4'h0, 4'h2, 4'h0);
        tick(12);

        // Held ch2 bounces 1,0,1,1,0 then stays 0: one release only.
        button = 4'h4;
        expect_pulse(6, 4'h4, 4'h0, 4'h4);
        tick(6);
        pat = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            button[2] = pat[4-i];
            if (i < 4) tick(1);
        end
        expect_pulse(6, 4'h0, 4'h4, 4'h0);
        tick(4);
        expect_now(4'h0, 4'h0, 4'h4);
        tick(8);

        // ch0 and ch3 together, reset mid-filter, re-press after reset.
        button = 4'h9;
        tick(4);
        expect_now(4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        tick(1);
        expect_now(4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        expect_pulse(6, 4'h9, 4'h0, 4'h9);
        tick(6);
        button = 4'h0;
        expect_pulse(6, 4'h0, 4'h9, 4'h0);
        tick(8);

        // ch0 held 30 cycles after its press; release lands on a would-be repeat.
        button = 4'h1;
        expect_pulse(6, 4'h1, 4'h0, 4'h1);
        tick(6);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        expect_pulse(10, 4'h1, 4'h0, 4'h1);
        expect_pulse(14, 4'h1, 4'h0, 4'h1);
        expect_pulse(18, 4'h1, 4'h0, 4'h1);
        expect_pulse(22, 4'h1, 4'h0, 4'h1);
        expect_pulse(26, 4'h1, 4'h0, 4'h1);
`endif
        tick(12);
        expect_now(4'h0, 4'h0, 4'h1);
        tick(12);
        button = 4'h0;
        expect_pulse(6, 4'h0, 4'h1, 4'h0);
        tick(12);
        expect_now(4'h0, 4'h0, 4'h0);

        tick(1);
        done = 1'b1;
        tick(4);
        $display("FAIL bench_end: monitor did not finish");
        $fatal(1);
    end

endmodule

// File: doc/button_debouncer_bank.md
# button_debouncer_bank

Parametrised multi-channel push-button conditioner for the board's input buttons. Each channel synchronises its raw pad input, filters bounce with a stable-count filter, and produces a clean debounced level plus single-cycle press and release pulses. Sits between the top-level button pads and control FSMs such as the pause/reset/adjust logic, and replaces ad-hoc per-button edge detectors. An optional auto-repeat mode re-fires the press pulse while a button is held.

## Interface
- `CHANNELS`, default 4: number of independent button channels, ≥1.
- `STABLE_CYCLES`, default 500000 (5 ms at 100 MHz): consecutive cycles the synchronised input must differ from the debounced level before the level flips, ≥1.
- `REPEAT_DELAY`, default 50000000: cycles from press to first auto-repeat, ≥1; used only with the repeat feature.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent auto-repeats, ≥1; used only with the repeat feature.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  CHANNELS  raw asynchronous button inputs, active-high.
- `button_level`  out  CHANNELS  debounced level.
- `button_press`  out  CHANNELS  one-cycle pulse on debounced 0→1, plus auto-repeat pulses when enabled.
- `button_release`  out  CHANNELS  one-cycle pulse on debounced 1→0.

## Operation
- Per channel: two-flop synchroniser (`sync1`, `sync2`), stable counter `cnt` (width `$clog2(STABLE_CYCLES+1)`), level register, registered pulse outputs.
- Every cycle: if `sync2 == level`, `cnt <= 0`. Else if `cnt == STABLE_CYCLES-1`, `level <= sync2`, `cnt <= 0`, and the matching pulse (press for 0→1, release for 1→0) is registered high for one cycle. Else `cnt <= cnt+1`.
- Any cycle where `sync2` returns to `level` restarts the filter; glitches shorter than `STABLE_CYCLES` never propagate.
- Channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- `button_press` and `button_release` of one channel never both high in the same cycle.
- Reset: synchroniser flops, `cnt`, level, all pulses, and repeat state cleared to 0. All outputs read 0 in the cycle after a reset edge. A button held through reset release is treated as a new press: press pulse after the normal latency.
- Reset mid-filter discards the partial count; no pulse is emitted for it.

## Timing
- Raw input changes before edge 1 and stays stable: `sync2` holds the new value after edge 2; `button_level` and the pulse update at edge 2+`STABLE_CYCLES`. Latency = `STABLE_CYCLES`+2 cycles.
- Pulses are exactly one cycle wide and coincide with the first cycle of the new `button_level` value.
- All outputs are registered; no combinational path from `button` to any output.
- Counter never exceeds `STABLE_CYCLES-1`; no wrap-around is possible.

## Configuration
- Macro `BUTTON_DEBOUNCER_REPEAT_EN`.
- Defined: per-channel repeat counter (width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`) clears on the press pulse. While `button_level` stays 1, the counter raises an additional one-cycle `button_press` pulse `REPEAT_DELAY` cycles after the initial press pulse, then every `REPEAT_PERIOD` cycles. Release or reset clears the counter and stops repeats immediately. No repeat pulse in the release cycle.
- Undefined: no repeat logic is synthesised, `REPEAT_*` parameters are ignored, and `button_press` fires only on the 0→1 transition. Port list is identical in both builds.

## Structure
- Package `button_debouncer_pkg`: default timing constants (`DEB_STABLE_5MS_100MHZ`, `DEB_REPEAT_DELAY_0S5`, `DEB_REPEAT_PERIOD_0S1`) and a width helper function for counter sizing.
- Sub-module `button_debouncer_channel`: one channel containing the synchroniser, filter, pulse, and optional repeat logic. The top instantiates `CHANNELS` copies in a generate loop.

## Test plan
Bench parameters: `CHANNELS`=4, `STABLE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4.
- Reset: `rst`=1 for 3 cycles with `button`=4'hF → all outputs 0 during reset. After release, `button_level`=4'hF and `button_press`=4'hF for one cycle, 6 cycles after release.
- Clean press on ch0 at edge 0 → `button_level[0]` and a single `button_press[0]` pulse at edge 6. No other channel toggles.
- 3-cycle glitch on ch1 → `button_level[1]` stays 0 and no pulses. A 4-cycle glitch → press at edge 6, then release 6 cycles after the glitch ends.
- Bounce pattern 1,0,1,1,0 then stable 0 on a held ch2 → exactly one `button_release[2]`, at 6 cycles after the last 1→0.
- ch0 and ch3 pressed on the same edge, `rst` pulsed while ch3 is mid-filter → ch0 and ch3 cleared; both re-press 6 cycles after reset release.
- With `BUTTON_DEBOUNCER_REPEAT_EN`, ch0 held for 30 cycles after its press → press pulses at offsets 0, 10, 14, 18, 22, 26. Release stops repeats. Without the macro → only the offset-0 pulse.
